// File: rtl/dac8568_pkg.sv
// rtl/dac8568_pkg.sv - DAC8568 command codes, scheduler states and word formatter
package dac8568_pkg;

  localparam logic [3:0] WR_INPUT  = 4'b0000;
  localparam logic [3:0] UPD_DAC   = 4'b0001;
  localparam logic [3:0] WR_UPD    = 4'b0011;
  localparam logic [3:0] SETUP_REF = 4'b1000;
  localparam logic [3:0] ADDR_ALL  = 4'hF;

  typedef enum logic [2:0] {
    S_WAIT_QUIET,
    S_INIT,
    S_IDLE,
    S_LOAD,
    S_ASSERT,
    S_WAIT_DONE,
    S_GAP
  } state_t;

  function automatic logic [31:0] format_word(input logic [3:0] ctrl,
                                              input logic [3:0] addr,
                                              input logic [15:0] value);
    return {4'b0000, ctrl, addr, value, 4'b0000};
  endfunction

endpackage

// File: rtl/dac8568_update_scheduler_rr_arbiter8.sv
// rtl/dac8568_update_scheduler_rr_arbiter8.sv - 8-way round-robin pick of the first pending channel at or after the pointer
module rr_arbiter8 (
  input  logic [7:0] i_pending,
  input  logic [2:0] i_ptr,
  output logic [2:0] o_grant,
  output logic       o_valid
);

  logic [2:0] w_idx;

  always_comb begin
    o_grant = '0;
    o_valid = 1'b0;
    w_idx   = '0;
    for (int k = 0; k < 8; k++) begin
      w_idx = i_ptr + k[2:0];
      if (!o_valid && i_pending[w_idx]) begin
        o_grant = w_idx;
        o_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/dac8568_update_scheduler.sv
// rtl/dac8568_update_scheduler.sv - coalesces per-channel DAC8568 updates and feeds the word serializer
module dac8568_update_scheduler
  import dac8568_pkg::*;
#(
  parameter logic [31:0] INIT_WORD   = 32'h0800_0001,
  parameter bit          INIT_EN     = 1'b1,
  parameter int          GAP_CYCLES  = 4,
  parameter int          ACK_TIMEOUT = 16,
  parameter logic [31:0] LDAC_WORD   = 32'h01F0_0000
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic [7:0]   i_ch_wr_en,
  input  logic [127:0] i_ch_data,
  input  logic         i_deferred,
  output logic [7:0]   o_ch_pending,
  output logic [31:0]  o_dac_data,
  output logic         o_dac_wr_en,
  input  logic         i_dac_busy,
  output logic         o_idle,
  output logic         o_init_done,
  output logic         o_error,
  input  logic         i_err_clr,
  output logic [15:0]  o_words_sent
);

  state_t      r_state, w_state_nxt;
  logic [15:0] r_shadow [8];
  logic [7:0]  r_pending;
  logic [2:0]  r_ptr;
  logic        r_dirty, r_init_done, r_error, r_wr_en, r_is_init;
  logic [31:0] r_dac_data, r_next_word;
  logic [15:0] r_cnt, r_words;
  logic [2:0]  w_gnt;
  logic        w_gnt_valid, w_ready;
  logic        w_take_ch, w_take_ldac, w_start, w_timeout, w_done;

  rr_arbiter8 u_arb (
    .i_pending (r_pending),
    .i_ptr     (r_ptr),
    .o_grant   (w_gnt),
    .o_valid   (w_gnt_valid)
  );

  assign w_ready = r_init_done || !INIT_EN;

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= S_WAIT_QUIET;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_take_ch   = 1'b0;
    w_take_ldac = 1'b0;
    w_start     = 1'b0;
    w_timeout   = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      S_WAIT_QUIET: if (!i_dac_busy) w_state_nxt = INIT_EN ? S_INIT : S_IDLE;
      S_INIT: begin
        w_start     = 1'b1;
        w_state_nxt = S_ASSERT;
      end
      S_IDLE: begin
        // Only reachable un-ready when the setup word timed out: retry it.
        if (!w_ready) begin
          w_state_nxt = S_INIT;
        end else if (w_gnt_valid) begin
          w_take_ch   = 1'b1;
          w_state_nxt = S_LOAD;
        end else if (r_dirty) begin
          w_take_ldac = 1'b1;
          w_state_nxt = S_LOAD;
        end
      end
      S_LOAD: begin
        w_start     = 1'b1;
        w_state_nxt = S_ASSERT;
      end
      S_ASSERT: begin
        if (i_dac_busy) begin
          w_state_nxt = S_WAIT_DONE;
        end else if (r_cnt == 16'(ACK_TIMEOUT - 1)) begin
          w_timeout   = 1'b1;
          w_state_nxt = S_GAP;
        end
      end
      S_WAIT_DONE: if (!i_dac_busy) begin
        w_done      = 1'b1;
        w_state_nxt = S_GAP;
      end
      S_GAP: if (r_cnt + 16'd1 >= 16'(GAP_CYCLES)) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_WAIT_QUIET;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < 8; i++) r_shadow[i] <= '0;
      r_pending   <= '0;
      r_ptr       <= '0;
      r_dirty     <= 1'b0;
      r_init_done <= 1'b0;
      r_error     <= 1'b0;
      r_wr_en     <= 1'b0;
      r_is_init   <= 1'b0;
      r_dac_data  <= '0;
      r_next_word <= '0;
      r_cnt       <= '0;
      r_words     <= '0;
    end else begin
      // A write in the grant cycle re-arms the channel; the granted word keeps the old shadow.
      for (int i = 0; i < 8; i++) begin
        if (i_ch_wr_en[i]) begin
          r_shadow[i]  <= i_ch_data[16*i +: 16];
          r_pending[i] <= 1'b1;
        end else if (w_take_ch && w_gnt == 3'(i)) begin
          r_pending[i] <= 1'b0;
        end
      end
      if (w_take_ch) begin
        r_next_word <= format_word(i_deferred ? WR_INPUT : WR_UPD, {1'b0, w_gnt}, r_shadow[w_gnt]);
        r_ptr       <= w_gnt + 3'd1;
        if (i_deferred) r_dirty <= 1'b1;
      end
      if (w_take_ldac) begin
        r_next_word <= LDAC_WORD;
        r_dirty     <= 1'b0;
      end
      if (w_start) begin
        r_dac_data <= (r_state == S_INIT) ? INIT_WORD : r_next_word;
        r_is_init  <= (r_state == S_INIT);
        r_wr_en    <= 1'b1;
      end
      if (r_state == S_ASSERT && (i_dac_busy || w_timeout)) r_wr_en <= 1'b0;
      if (w_timeout)      r_error <= 1'b1;
      else if (i_err_clr) r_error <= 1'b0;
      if (w_done) begin
        r_words <= r_words + 16'd1;
        if (r_is_init) r_init_done <= 1'b1;
      end
      if (r_state == S_IDLE && !INIT_EN) r_init_done <= 1'b1;
      r_cnt <= (w_state_nxt != r_state) ? 16'd0 : r_cnt + 16'd1;
    end
  end

  assign o_ch_pending = r_pending;
  assign o_dac_data   = r_dac_data;
  assign o_dac_wr_en  = r_wr_en;
  assign o_idle       = (r_state == S_IDLE) && (r_pending == 8'd0) && !r_dirty;
  assign o_init_done  = r_init_done;
  assign o_error      = r_error;
  assign o_words_sent = r_words;

endmodule

// File: doc/dac8568_update_scheduler.md
Name: dac8568_update_scheduler

Overview:
- Sequences the single-word DAC8568 serializer for eight DAC channels.
- Latches per-channel update requests from the sequencer/host side and coalesces them, so the latest value wins.
- Arbitrates the pending requests round-robin and formats 32-bit DAC8568 command words.
- Sends the reference-setup word after reset, and optionally a software-LDAC "update all" word after deferred writes.

Parameters:
- INIT_WORD, 32'h0800_0001, setup word sent once after reset (internal reference, static mode).
- INIT_EN, 1, 0 skips the init word; init_done rises at the first IDLE.
- GAP_CYCLES, 4, minimum idle cycles between words (SYNC high time); range 0..255.
- ACK_TIMEOUT, 16, cycles to wait for dac_busy to rise after dac_wr_en asserts.
- LDAC_WORD, 32'h01F0_0000, update-all-DAC-registers word (ctrl 0001, addr 1111).

Ports:
- clk, in, 1, system clock.
- rst, in, 1, synchronous active-high reset.
- ch_wr_en, in, 8, per-channel write strobe, level-sampled each cycle.
- ch_data, in, 128, channel i value is bits [16i+15:16i].
- deferred, in, 1, 0 = write and update (ctrl 0011); 1 = write input register only (ctrl 0000) plus a later LDAC word.
- ch_pending, out, 8, channel has a latched value not yet sent.
- dac_data, out, 32, word presented to the serializer.
- dac_wr_en, out, 1, write request to the serializer.
- dac_busy, in, 1, serializer busy.
- idle, out, 1, IDLE state, nothing pending, dirty clear.
- init_done, out, 1, init word completed (sticky until rst).
- error, out, 1, sticky ack timeout; cleared by err_clr.
- err_clr, in, 1, clears error.
- words_sent, out, 16, count of completed words; wraps 0xFFFF to 0.

Behaviour:
- Reset values: dac_wr_en 0; dac_data 0; ch_pending 0; shadow registers 0; RR pointer 0; dirty 0; init_done 0; error 0; words_sent 0; idle 0; state WAIT_QUIET.
- Word format: {4'b0000, ctrl[3:0], addr[3:0], value[15:0], 4'b0000}, with addr = channel index.
- Request latch: ch_wr_en[i] high → shadow[i] <= slice and ch_pending[i] <= 1 at the next edge, every cycle, in any state.
- Grant: clears ch_pending[i]. A write to the same channel in the grant cycle keeps ch_pending[i]=1 and stores the new value; the granted word carries the old value.
- Arbitration: in IDLE, grant the first pending channel at or after the RR pointer, wrapping 7→0. Pointer <= grant+1 mod 8. Grant-to-dac_wr_en is 1 cycle (LOAD).
- deferred is sampled at grant. Deferred writes set dirty.
- WAIT_QUIET: wait until dac_busy==0 (the serializer is not reset by rst), then go to INIT if INIT_EN, else IDLE.
- INIT: load INIT_WORD → ASSERT; on completion set init_done.
- IDLE priority: pending channel first; else dirty → load LDAC_WORD and clear dirty at load; else stay (idle=1). Requests are accepted during INIT but not granted until init_done.
- LOAD: register dac_data → ASSERT.
- ASSERT: dac_wr_en=1 and dac_data stable. On dac_busy==1 → dac_wr_en<=0, go to WAIT_DONE.
  - Timeout: if busy is not seen within ACK_TIMEOUT cycles, dac_wr_en<=0, error<=1, word dropped (not counted, pending not restored) → GAP.
- WAIT_DONE: on dac_busy==0 → words_sent+1 → GAP. dac_data is held until GAP ends.
- GAP: count GAP_CYCLES, then → IDLE. GAP_CYCLES=0 means 1 cycle through GAP.
- Each word drops dac_wr_en, which guarantees a fresh rising edge for the serializer's edge detector.
- err_clr and a timeout in the same cycle: error stays 1.
- rst mid-word: everything returns to reset values immediately; the in-flight serial word completes in the serializer; WAIT_QUIET absorbs it.

Decomposition:
- Shared package dac8568_pkg holds:
  - control code constants: WR_INPUT=4'b0000, UPD_DAC=4'b0001, WR_UPD=4'b0011, SETUP_REF=4'b1000;
  - ADDR_ALL=4'hF;
  - state enum;
  - the format_word function.
- Sub-module rr_arbiter8: pending[7:0] plus pointer in; grant index and valid out; combinational priority rotate.

Test Plan:
- Reset, dac_busy model (busy 1 cycle after wr_en edge, 32 cycles) → first word 0x0800_0001, init_done=1, words_sent=1.
- ch_wr_en[3] pulse, data 0xABCD, deferred=0 → dac_data 0x033A_BCD0, ch_pending[3] clears at grant, words_sent=2.
- ch 5 writes 0x1111 then 0x2222 before grant → one word 0x0352_2220. A write 0x3333 in the grant cycle → a second word 0x0353_3330.
- All 8 channels pending, pointer 0 → grant order 0..7. Then ch 2 and ch 0 are pending with pointer 1 → ch 2 before ch 0.
- deferred=1, ch 1 and ch 6 written → 0x0016_xxx0, 0x0066_xxx0, then 0x01F0_0000 once; idle=1 afterwards.
- dac_busy tied 0 → dac_wr_en drops after 16 cycles, error=1, words_sent unchanged. err_clr clears error. rst asserted during WAIT_DONE → outputs reset, then re-init after dac_busy falls.
